// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared constants and helpers for the I2S transmit path.
//   SAMPLE_W   : bits per channel sample (fixed 16, the frame has 32 slots)
//   CNT_W      : width of the free-running frame counter (512 clk per frame)
//   *_BIT      : counter bit that directly drives each DAC clock
//   FRAME_LAST : counter value on whose edge a new stereo pair is captured
//   SLOTS      : bit slots per frame (16 left + 16 right)
//   slot_sel_e : source of the serial bit for a given slot
//   capture_value() : mute / attenuation applied to a sample at capture time
// -----------------------------------------------------------------------------
package audio_pkg;

  localparam int unsigned SAMPLE_W = 32'd16;
  localparam int unsigned CNT_W    = 32'd9;

  localparam int unsigned MCLK_BIT = 32'd1;
  localparam int unsigned SCK_BIT  = 32'd3;
  localparam int unsigned LRCK_BIT = 32'd8;

  localparam logic [CNT_W-1:0] FRAME_LAST = 9'd511;
  localparam int unsigned      SLOTS      = 32'd32;

  // Where the bit for the upcoming slot comes from.
  typedef enum logic [1:0] {
    SEL_PREV_LSB = 2'd0,  // slot 0: right LSB left over from the previous frame
    SEL_LEFT     = 2'd1,  // slots 1..16: left sample, MSB first
    SEL_RIGHT    = 2'd2   // slots 17..31: right sample bits 15..1
  } slot_sel_e;

  // Value latched into a hold register: zero when muted, otherwise the sample
  // arithmetically shifted right (sign preserved, truncating toward -inf, so
  // -1 stays -1). With attenuation disabled the sample passes unchanged.
  function automatic logic [SAMPLE_W-1:0] capture_value(
    input logic [SAMPLE_W-1:0] sample,
    input logic                mute,
    input logic                vol_en,
    input logic [2:0]          shift
  );
    logic signed [SAMPLE_W-1:0] s_val;
    logic [SAMPLE_W-1:0]        result;
    s_val = $signed(sample);
    if (mute) begin
      result = {SAMPLE_W{1'b0}};
    end else if (vol_en) begin
      result = s_val >>> shift;
    end else begin
      result = sample;
    end
    return result;
  endfunction

endpackage

// File: rtl/i2s_audio_tx.sv
// -----------------------------------------------------------------------------
// i2s_audio_tx
// Serialises 16-bit signed stereo samples to an I2S DAC and generates all DAC
// clocks from the 100 MHz system clock using one free-running 9-bit counter.
//
// Ports:
//   clk          in   system clock (100 MHz)
//   rst          in   asynchronous, active-high reset
//   audio_left   in   left sample, two's complement
//   audio_right  in   right sample, two's complement
//   mute         in   1 = capture zeros instead of the inputs
//   vol_shift    in   arithmetic right shift applied at capture (0..7)
//   sample_tick  out  one-cycle pulse in the cycle after a capture
//   audio_mclk   out  master clock, clk/4
//   audio_sck    out  bit clock, clk/16
//   audio_lrck   out  word select, clk/512 (0 = left, 1 = right)
//   audio_sdin   out  serial data, MSB first, one-bit I2S delay
// -----------------------------------------------------------------------------
module i2s_audio_tx
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W = 32'd16,
  parameter bit          VOL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] audio_left,
  input  logic [DATA_W-1:0] audio_right,
  input  logic              mute,
  input  logic [2:0]        vol_shift,
  output logic              sample_tick,
  output logic              audio_mclk,
  output logic              audio_sck,
  output logic              audio_lrck,
  output logic              audio_sdin
);

  logic [CNT_W-1:0]    cnt_r;
  logic [SAMPLE_W-1:0] l_hold_r;
  logic [SAMPLE_W-1:0] r_hold_r;
  logic                sdin_r;
  logic                tick_r;

  logic                frame_end_s;
  logic                slot_end_s;
  logic [4:0]          next_slot_s;
  logic [3:0]          bit_idx_s;
  slot_sel_e           sel_s;
  logic                next_bit_s;

  // Frame and slot boundary decode from the counter.
  always_comb begin
    frame_end_s = (cnt_r == FRAME_LAST);
    slot_end_s  = (cnt_r[3:0] == 4'hF);
    // Slot that begins on the coming edge; wraps 31 -> 0 at the frame end.
    next_slot_s = cnt_r[8:4] + 5'd1;
  end

  // Choose the bit source for the upcoming slot.
  always_comb begin
    sel_s     = SEL_PREV_LSB;
    bit_idx_s = 4'd0;
    if (next_slot_s == 5'd0) begin
      sel_s     = SEL_PREV_LSB;
      bit_idx_s = 4'd0;
    end else if (next_slot_s <= 5'd16) begin
      sel_s     = SEL_LEFT;
      // Slot n carries bit 16-n; modulo 16 that is simply -n.
      bit_idx_s = 4'd0 - next_slot_s[3:0];
    end else begin
      sel_s     = SEL_RIGHT;
      // Slot n carries bit 32-n; modulo 16 that is again -n.
      bit_idx_s = 4'd0 - next_slot_s[3:0];
    end
  end

  // Fetch the serial bit for the upcoming slot.
  always_comb begin
    next_bit_s = 1'b0;
    case (sel_s)
      // At the frame-end edge r_hold_r still holds the outgoing frame's right
      // sample, so its LSB is the delayed bit owed to slot 0 of the new frame.
      SEL_PREV_LSB: next_bit_s = r_hold_r[0];
      SEL_LEFT:     next_bit_s = l_hold_r[bit_idx_s];
      SEL_RIGHT:    next_bit_s = r_hold_r[bit_idx_s];
      default:      next_bit_s = 1'b0;
    endcase
  end

  // Free-running frame counter; every DAC clock is a bit of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + 9'd1;
    end
  end

  // Capture the stereo pair once per frame, on the last counter value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_hold_r <= {SAMPLE_W{1'b0}};
      r_hold_r <= {SAMPLE_W{1'b0}};
    end else if (frame_end_s) begin
      l_hold_r <= capture_value(audio_left,  mute, VOL_EN, vol_shift);
      r_hold_r <= capture_value(audio_right, mute, VOL_EN, vol_shift);
    end else begin
      l_hold_r <= l_hold_r;
      r_hold_r <= r_hold_r;
    end
  end

  // Tell upstream a pair was taken: high while cnt == 0 after a capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_r <= 1'b0;
    end else begin
      tick_r <= frame_end_s;
    end
  end

  // Serial data flop, updated together with the sck falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdin_r <= 1'b0;
    end else if (slot_end_s) begin
      sdin_r <= next_bit_s;
    end else begin
      sdin_r <= sdin_r;
    end
  end

  assign audio_mclk  = cnt_r[MCLK_BIT];
  assign audio_sck   = cnt_r[SCK_BIT];
  assign audio_lrck  = cnt_r[LRCK_BIT];
  assign audio_sdin  = sdin_r;
  assign sample_tick = tick_r;

endmodule

// File: doc/i2s_audio_tx.md
Name: i2s_audio_tx

Overview:
- Transmit end of the audio sample path: consumes the parallel 16-bit signed left/right samples produced by the tone generators and serializes them to the on-board stereo DAC (PMOD I2S2 class) in standard I2S format.
- Generates all DAC clocks (MCLK, SCK, LRCK) from the 100 MHz system clock.
- Captures one stereo sample pair per frame, with mute and volume attenuation, and tells upstream when a sample has been taken.

Parameters:
- DATA_W, 16, sample width per channel. Only 16 is supported because the 32-slot frame is fixed.
- VOL_EN, 1, 1 = apply vol_shift attenuation at capture; 0 = ignore vol_shift.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- audio_left  in  16  signed left sample, two's complement
- audio_right  in  16  signed right sample
- mute  in  1  1 = capture zeros instead of the inputs
- vol_shift  in  3  arithmetic right-shift amount applied at capture (0..7)
- sample_tick  out  1  one-cycle pulse: a new pair was captured on the previous edge
- audio_mclk  out  1  master clock, clk/4
- audio_sck  out  1  bit clock, clk/16
- audio_lrck  out  1  word select, clk/512; 0 = left, 1 = right
- audio_sdin  out  1  serial data, MSB first, I2S one-bit delay

Behaviour:
- Interface decision: reset rst, asynchronous, active-high; clock clk.
- Free-running 9-bit counter cnt, +1 per clk, wraps 511 -> 0.
- Clock outputs are direct counter bits, so they are glitch-free:
  - mclk = cnt[1]
  - sck = cnt[3]
  - lrck = cnt[8]
- Slot index s = cnt[8:4], range 0..31. sck falls at each slot start (cnt[3:0]==0); the DAC samples sdin on the sck rise.
- Capture, on the edge where cnt==511:
  - L_hold <= mute ? 0 : (VOL_EN ? audio_left >>> vol_shift : audio_left)
  - R_hold is formed the same way from audio_right.
  - The shift is arithmetic and sign-preserving. A result of -1 stays -1; there is no rounding.
  - The previous R_hold[0] is saved as r_lsb_prev.
- sample_tick is registered: high for exactly the cycle where cnt==0 after a capture.
- Inputs may change at any time. Only the value present at the cnt==511 edge is used, and it is emitted in the following frame.
- Serial stream for the frame following a capture:
  - slot 0 = r_lsb_prev
  - slots 1..16 = L_hold[15..0]
  - slots 17..31 = R_hold[15..1]
  - R_hold[0] goes out in slot 0 of the next frame.
- sdin is a flop updated on the same edge that brings cnt[3:0] to 0. It is constant for the full 16 clk of a slot, and the transition is aligned with the sck falling edge.
- Reset values, held while rst is high and taking effect immediately when rst asserts:
  - cnt = 0, so mclk = sck = lrck = 0
  - sdin = 0, sample_tick = 0
  - L_hold = R_hold = 0, r_lsb_prev = 0
- After reset release:
  - The first frame (cnt 0..511) transmits all zeros.
  - The first capture occurs at the 512th rising edge after release.
  - sample_tick first pulses one cycle later.
- Reset mid-frame truncates the frame with no partial-state recovery. The DAC sees lrck and sck stop low.
- No handshake back-pressure: upstream must hold a valid sample at each cnt==511 edge. A steady-state sample rate of 195.3125 kHz (100 MHz / 512) is acceptable.

Decomposition:
- Package audio_pkg holds:
  - SAMPLE_W = 16, CNT_W = 9
  - MCLK_BIT = 1, SCK_BIT = 3, LRCK_BIT = 8
  - FRAME_LAST = 9'd511, SLOTS = 32
  - helper function for the attenuated/muted capture value
- Single module. The counter, capture registers and slot-indexed bit select are small enough that no sub-module is warranted.

Test Plan:
- Hold rst high for 10 cycles, then release -> all outputs 0 during reset. After release: mclk period 4 clk, sck period 16 clk, lrck period 512 clk, lrck rises when cnt==256, first frame sdin all 0.
- audio_left=16'hA5C3, audio_right=16'h3C5A, vol_shift=0, mute=0 -> sample_tick pulses at cycle 512. Next frame: slot1=1, slots 1..16 = A5C3 MSB-first, slot16=1, slot17=0, slots 17..31 = 3C5A[15:1]; slot 0 of the following frame = 0.
- vol_shift=2, audio_left=16'h8000, audio_right=16'h7FFF -> captured and serialized L=16'hE000, R=16'h1FFF. Repeat with vol_shift=7, audio_left=16'hFFFF -> L=16'hFFFF.
- mute=1 with nonzero inputs -> every sdin slot 0 (except a residual slot-0 R LSB from the pre-mute frame). sample_tick keeps pulsing every 512 clk.
- Change audio_left from 16'h1234 to 16'h5678 at cnt==100 -> current frame unaffected. The frame after the next capture carries 16'h5678; no mixed bits.
- Assert rst at cnt==300 -> sdin, sck, lrck and sample_tick go to 0 immediately. After release, one zero frame, then a capture at 512 clk.
